// File: rtl/muldiv_unit_if.sv
// Purpose : request/response bundle between the EX stage and muldiv_unit.
// Latency : n/a (wires only).
// Backpressure: start/busy/done handshake; requester holds off while busy.
// Ports   : start/op/a/b launch an op, cancel squashes it, hi_we/lo_we/wd are
//           direct HI/LO writes, busy/done/divzero/hi/lo come back.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel, hi_we, lo_we, wd,
        input  busy, done, divzero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, hi_we, lo_we, wd,
        output busy, done, divzero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Purpose : iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Latency : WIDTH+1 edges start->done (divide-by-zero: 1 edge); with
//           MULDIV_EARLY_OUT_EN multiplies take max(1,bitlen|b|)+1 edges.
// Backpressure: start is only sampled in IDLE; busy stays high until done.
// Ports   : clk, reset_n (async active-low), bus (muldiv_unit_if.slave):
//           start/op/a/b/cancel/hi_we/lo_we/wd in, busy/done/divzero/hi/lo out.
// Config  : `define MULDIV_EARLY_OUT_EN enables multiply early termination.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        cnt;
    logic                 op_div;
    logic                 neg_q;       // negate product / quotient in FIX
    logic                 neg_r;       // negate remainder in FIX
    logic                 dz;          // in-flight divide has zero divisor
    // Multiply: acc accumulates, mcand is |a| shifted left, mp is |b| shifted right.
    // Divide  : acc[WIDTH-1:0] is the partial remainder, mcand[WIDTH-1:0] is |b|,
    //           mp shifts the dividend out and the quotient in.
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mp;

    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q, divzero_q;

    // ---------------- operand conditioning at launch ----------------
    logic             op_signed, a_neg, b_neg, b_zero, launch;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        op_signed = ~bus.op[0];
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        b_zero    = (bus.b == '0);
        // cancel in IDLE swallows a coincident start
        launch    = (state == IDLE) && bus.start && !bus.cancel;
    end

    // ---------------- one iteration step ----------------
    logic [WIDTH:0]     rem_sh, diff;
    logic               qbit;
    logic [2*WIDTH-1:0] mul_add;
    logic               run_last;

    always_comb begin
        rem_sh  = {acc[WIDTH-1:0], mp[WIDTH-1]};
        diff    = rem_sh - {1'b0, mcand[WIDTH-1:0]};
        qbit    = ~diff[WIDTH];
        mul_add = acc + (mp[0] ? mcand : {2*WIDTH{1'b0}});
`ifdef MULDIV_EARLY_OUT_EN
        // stop once no set multiplier bits remain after this step
        run_last = (cnt == '0) || (!op_div && (mp[WIDTH-1:1] == '0));
`else
        run_last = (cnt == '0);
`endif
    end

    // ---------------- FSM ----------------
    logic commit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (launch)
                    state_nxt = (bus.op[1] && b_zero) ? FIX : RUN;
            end
            RUN: begin
                if (bus.cancel)    state_nxt = IDLE;
                else if (run_last) state_nxt = FIX;
            end
            FIX: begin
                state_nxt = IDLE;
                commit    = !bus.cancel;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- sign fix-up / result select ----------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -mp : mp;
        rem  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (!op_div) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dz) begin
            res_hi = acc[WIDTH-1:0];   // raw dividend parked here at launch
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        op_div <= bus.op[1];
                        dz     <= bus.op[1] & b_zero;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= bus.op[1] & a_neg;
                        cnt    <= CW'(WIDTH - 1);
                        mp     <= bus.op[1] ? a_mag : b_mag;
                        mcand  <= {{WIDTH{1'b0}}, (bus.op[1] ? b_mag : a_mag)};
                        acc    <= (bus.op[1] && b_zero) ? {{WIDTH{1'b0}}, bus.a}
                                                        : {2*WIDTH{1'b0}};
                    end
                end
                RUN: begin
                    if (!bus.cancel) begin
                        if (!run_last) cnt <= cnt - 1'b1;
                        if (op_div) begin
                            acc <= {{WIDTH{1'b0}}, (qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0])};
                            mp  <= {mp[WIDTH-2:0], qbit};
                        end else begin
                            acc   <= mul_add;
                            mcand <= mcand << 1;
                            mp    <= mp >> 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- architectural registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            done_q <= commit;
            // operation result beats a coincident mthi/mtlo
            if (commit)          hi_q <= res_hi;
            else if (bus.hi_we)  hi_q <= bus.wd;
            if (commit)          lo_q <= res_lo;
            else if (bus.lo_we)  lo_q <= bus.wd;
            if (commit && op_div) divzero_q <= dz;
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.divzero = divzero_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose : self-checking bench for muldiv_unit against an arithmetic model.
// Latency : checks start->done edge count for every operation.
// Backpressure: drives start only while idle, except deliberate start-while-busy.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int   n_vec = 0;
    int   n_bad = 0;
    logic model_dz = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] r;
        longint      p;
        int          sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'd0: begin p = longint'(sa) * longint'(sb); r = p; end
            2'd1: r = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0)                                  r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == '1)      r = {32'h0, 32'h8000_0000};
                else                                         r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        if (op[1] && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            logic [31:0] mag;
            int          bl;
            mag = (op == 2'd0 && b[31]) ? -b : b;
            bl  = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
            return ((bl < 1) ? 1 : bl) + 1;
        end
`endif
        return W + 1;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after a rising edge with the unit idle; returns the same way.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [63:0] exp;
        int          lat;
        bit          busy_ok;
        exp     = ref_result(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;                 // E0
        bus.start = 1'b0;
        bus.a     = $urandom;               // operands must have been captured
        bus.b     = $urandom;
        lat       = 0;
        busy_ok   = 1'b1;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            bus.start = 1'b0;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
            if (poke && lat == 1) begin     // start while busy: must be ignored
                bus.start = 1'b1;
                bus.op    = ~op;
            end
        end
        bus.start = 1'b0;
        if (op[1]) model_dz = (b == 0);
        check({tag, " latency"}, 64'(lat), 64'(ref_latency(op, b)));
        check({tag, " busy"}, {63'b0, busy_ok & ~bus.busy}, 64'd1);
        check({tag, " hi:lo"}, {bus.hi, bus.lo}, exp);
        check({tag, " divzero"}, {63'b0, bus.divzero}, {63'b0, model_dz});
        @(posedge clk); #1;
        check({tag, " done pulse"}, {63'b0, bus.done}, 64'd0);
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        bus.hi_we = 1'b1; bus.wd = h;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wd = l;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
    endtask

    initial begin
        bit seen;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hi:lo", {bus.hi, bus.lo}, 64'd0);
        check("reset busy/done/dz", {61'b0, bus.busy, bus.done, bus.divzero}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult -3*7",      2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        run_op("multu max*max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div -7/2",       2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op("div min/-1",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("multu 5*3",      2'd1, 32'h0000_0005, 32'h0000_0003, 1'b0);
        run_op("mult poke",      2'd0, 32'h0001_2345, 32'hFFFF_0001, 1'b1);
        run_op("divu 100/0",     2'd3, 32'h0000_0064, 32'h0000_0000, 1'b0);

        // cancel mid-operation: HI/LO and divzero keep pre-op values
        preload(32'h11, 32'h22);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'h5; bus.b = 32'hC000_0003;
        @(posedge clk); #1;                 // E0
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;                 // E10
        bus.cancel = 1'b0;
        check("cancel busy", {63'b0, bus.busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("cancel no done", {63'b0, seen}, 64'd0);
        check("cancel hi:lo", {bus.hi, bus.lo}, {32'h11, 32'h22});
        check("cancel divzero", {63'b0, bus.divzero}, {63'b0, model_dz});

        // reset mid-operation
        preload(32'h11, 32'h22);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'h5; bus.b = 32'hC000_0003;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        model_dz = 1'b0;
        check("mid reset hi:lo", {bus.hi, bus.lo}, 64'd0);
        check("mid reset busy/dz", {62'b0, bus.busy, bus.divzero}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // cancel in IDLE drops a coincident start
        preload(32'h33, 32'h44);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'd1; bus.a = 32'h9; bus.b = 32'h9;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        check("idle cancel busy", {63'b0, bus.busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("idle cancel quiet", {63'b0, seen}, 64'd0);
        check("idle cancel hi:lo", {bus.hi, bus.lo}, {32'h33, 32'h44});

        // mthi/mtlo with start lands now; the FIX result wins on the completion edge
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'hDEAD_BEEF;
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'h1234; bus.b = 32'h0;
        @(posedge clk); #1;                 // E0
        bus.start = 1'b0;
        check("we with start", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        @(posedge clk); #1;                 // E1 = FIX edge
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        model_dz = 1'b1;
        check("fix beats we", {bus.hi, bus.lo}, {32'h1234, 32'hFFFF_FFFF});
        check("fix done", {62'b0, bus.done, bus.divzero}, 64'd3);
        @(posedge clk); #1;

        // randomized operations with corner-biased operands
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d op%0d", i, op), op, rnd_operand(), rnd_operand(), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
